// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: decoder load/store codes and load/store unit types.
package cpu_pkg;

  localparam logic [2:0] LOAD_DISABLE = 3'd0;
  localparam logic [2:0] LOAD_LB      = 3'd1;
  localparam logic [2:0] LOAD_LH      = 3'd2;
  localparam logic [2:0] LOAD_LW      = 3'd3;
  localparam logic [2:0] LOAD_LBU     = 3'd4;
  localparam logic [2:0] LOAD_LHU     = 3'd5;

  localparam logic [1:0] STORE_DISABLE = 2'd0;
  localparam logic [1:0] STORE_SB      = 2'd1;
  localparam logic [1:0] STORE_SH      = 2'd2;
  localparam logic [1:0] STORE_SW      = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} lsu_size_e;

  // A non-zero load code takes precedence; unknown load codes behave as no-ops.
  function automatic lsu_size_e access_size(input logic [2:0] load, input logic [1:0] store);
    lsu_size_e sz;
    sz = SZ_NONE;
    if (load != LOAD_DISABLE) begin
      case (load)
        LOAD_LB, LOAD_LBU: sz = SZ_B;
        LOAD_LH, LOAD_LHU: sz = SZ_H;
        LOAD_LW:           sz = SZ_W;
        default:           sz = SZ_NONE;
      endcase
    end else begin
      case (store)
        STORE_SB: sz = SZ_B;
        STORE_SH: sz = SZ_H;
        STORE_SW: sz = SZ_W;
        default:  sz = SZ_NONE;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] offset);
    return ((sz == SZ_H) && offset[0]) || ((sz == SZ_W) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for outgoing accesses and extract/extend of returned load words.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]  req_load,
  input  logic [1:0]  req_store,
  input  logic [1:0]  req_offset,
  input  logic [31:0] req_wdata,
  output lsu_size_e   req_size,
  output logic        req_we,
  output logic [3:0]  req_be,
  output logic [31:0] req_lane_wdata,
  input  logic [2:0]  ext_load,
  input  logic [1:0]  ext_offset,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ext_data
);

  logic [31:0] byte_word;
  logic [31:0] half_word;

  assign req_size = access_size(req_load, req_store);
  assign req_we   = (req_load == LOAD_DISABLE) && (req_size != SZ_NONE);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    req_be         = 4'b0000;
    req_lane_wdata = 32'h0;
    case (req_size)
      SZ_B: begin
        req_be         = 4'b0001 << req_offset;
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        req_be         = 4'b0011 << {req_offset[1], 1'b0};
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
      end
      default: ;
    endcase
  end

  assign byte_word = bus_rdata >> {ext_offset, 3'b000};
  assign half_word = bus_rdata >> {ext_offset[1], 4'b0000};

  always_comb begin
    ext_data = 32'h0;
    case (ext_load)
      LOAD_LB:  ext_data = {{24{byte_word[7]}}, byte_word[7:0]};
      LOAD_LH:  ext_data = {{16{half_word[15]}}, half_word[15:0]};
      LOAD_LW:  ext_data = bus_rdata;
      LOAD_LBU: ext_data = {24'h0, byte_word[7:0]};
      LOAD_LHU: ext_data = {16'h0, half_word[15:0]};
      default:  ext_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// EX/MEM load/store unit driving a req/gnt/rvalid data bus with byte enables.
// Optional feature: define LSU_MISALIGN_TRAP_EN to answer misaligned H/W accesses with resp_err, no bus traffic.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  is_load,
  input  logic [1:0]  is_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e           state_q, state_d;
  logic [2:0]           load_q;
  logic [1:0]           offset_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 timeout_hit;
  logic                 trap;
  lsu_size_e            req_size;
  logic                 lane_we;
  logic [3:0]           lane_be;
  logic [31:0]          lane_wdata;
  logic [31:0]          ext_data;

  lsu_align u_align (
    .req_load       (is_load),
    .req_store      (is_store),
    .req_offset     (addr[1:0]),
    .req_wdata      (wdata),
    .req_size       (req_size),
    .req_we         (lane_we),
    .req_be         (lane_be),
    .req_lane_wdata (lane_wdata),
    .ext_load       (load_q),
    .ext_offset     (offset_q),
    .bus_rdata      (dmem_rdata),
    .ext_data       (ext_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_size, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Abort on the last permitted WAIT cycle; a response arriving in that same cycle still wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_cnt == TIMEOUT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = ((req_size == SZ_NONE) || trap) ? RESP : REQ;
      REQ:  if (dmem_gnt) state_d = WAIT;
      WAIT: if (dmem_rvalid || timeout_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      load_q      <= LOAD_DISABLE;
      offset_q    <= 2'b00;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      timeout_cnt <= '0;
      dmem_we     <= 1'b0;
      dmem_be     <= 4'b0000;
      dmem_addr   <= 32'h0;
      dmem_wdata  <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          load_q     <= is_load;
          offset_q   <= addr[1:0];
          dmem_addr  <= {addr[31:2], 2'b00};
          dmem_be    <= lane_be;
          dmem_we    <= lane_we;
          dmem_wdata <= lane_wdata;
          rdata_q    <= 32'h0;
          err_q      <= trap;
        end
        REQ: if (dmem_gnt) timeout_cnt <= '0;
        WAIT: begin
          timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
          if (dmem_rvalid) rdata_q <= ext_data;
          else if (timeout_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign dmem_req   = (state_q == REQ);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, timeout, reset and randomized traffic vs a reference model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  is_load;
  logic [1:0]  is_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .is_load     (is_load),
    .is_store    (is_store),
    .addr        (addr),
    .wdata       (wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          resp_cyc;
    int          req_cycles;
    bit          stable;
    bit          ready_busy;
    bit          ready_after;
    bit          pulse_again;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  typedef struct {
    bit          bus;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  // Reference: access width in bytes, effective offset, lanes and extension from plain arithmetic.
  function automatic exp_t model(input int ld, input int st, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int gw, input int rw);
    exp_t e;
    int size, off;
    bit trap, timeout;
    logic [31:0] v, mask;
    size = 0;
    if (ld == 1 || ld == 4) size = 1;
    else if (ld == 2 || ld == 5) size = 2;
    else if (ld == 3) size = 4;
    else if (ld == 0) size = (st == 3) ? 4 : st;
    off = int'(a % 4);
    if (size == 2) off = (off / 2) * 2;
    if (size == 4) off = 0;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0);
`endif
    e.bus   = (size != 0) && !trap;
    e.addr  = (a / 4) * 4;
    e.we    = (ld == 0) && (size != 0);
    e.be    = (size == 0) ? 4'b0000 : 4'(((1 << size) - 1) << off);
    e.wdata = (size == 1) ? wd[7:0] * 32'h01010101 :
              (size == 2) ? wd[15:0] * 32'h00010001 : wd;
    timeout = e.bus && (rw < 0 || rw >= TO);
    e.err   = trap || timeout;
    e.rdata = 32'h0;
    if (ld != 0 && e.bus && !timeout) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
      v = (rd >> (8 * off)) & mask;
      if ((ld == 1 || ld == 2) && v[8 * size - 1]) v = v | ~mask;
      e.rdata = v;
    end
    if (!e.bus) e.lat = 1;
    else if (timeout) e.lat = 2 + gw + TO;
    else e.lat = 3 + gw + rw;
    return e;
  endfunction

  // Drives one transaction from IDLE and records what the DUT did; callers do the comparisons.
  task automatic run_txn(input int ld, input int st, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int gw, input int rw, output obs_t o);
    bit granted;
    int wc;
    o = '{resp_cyc: -1, req_cycles: 0, stable: 1'b1, ready_busy: 1'b0, ready_after: 1'b0,
          pulse_again: 1'b0, addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0, rdata: 32'h0, err: 1'b0};
    req_valid = 1'b1;
    is_load   = 3'(ld);
    is_store  = 2'(st);
    addr      = a;
    wdata     = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    is_load   = 3'($urandom);
    is_store  = 2'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
    granted   = 1'b0;
    wc        = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (resp_valid) begin
        o.resp_cyc = cyc;
        o.rdata    = resp_rdata;
        o.err      = resp_err;
        break;
      end
      if (req_ready) o.ready_busy = 1'b1;
      if (dmem_req) begin
        if (o.req_cycles == 0) begin
          o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.wdata = dmem_wdata;
        end else if ({o.addr, o.be, o.we, o.wdata} !== {dmem_addr, dmem_be, dmem_we, dmem_wdata}) begin
          o.stable = 1'b0;
        end
        o.req_cycles++;
        if (o.req_cycles > gw) begin
          dmem_gnt = 1'b1;
          granted  = 1'b1;
        end
      end else if (granted) begin
        wc++;
        if (rw >= 0 && wc > rw) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rd;
        end
      end
      @(posedge clk); #1;
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    o.ready_after = req_ready;
    o.pulse_again = resp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; is_load = 3'd0; is_store = 2'd0; addr = 32'h0; wdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, dmem_req, dmem_we, dmem_be} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b rv=%b err=%b req=%b we=%b be=%b, want ready=1 rest 0",
               req_ready, resp_valid, resp_err, dmem_req, dmem_we, dmem_be);
    end
    checks++;
    if ({dmem_addr, dmem_wdata, resp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_regs: got addr=%h wdata=%h rdata=%h, want all 0", dmem_addr, dmem_wdata, resp_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    obs_t o;
    run_txn(1, 0, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 0, o);
    checks++;
    if ({o.addr, o.be, o.we, o.rdata, o.err} !== {32'h0000_1000, 4'b1000, 1'b0, 32'hFFFF_FF80, 1'b0}) begin
      errors++;
      $display("FAIL lb_sign: got addr=%h be=%b we=%b rdata=%h err=%b, want 00001000 1000 0 ffffff80 0",
               o.addr, o.be, o.we, o.rdata, o.err);
    end
    checks++;
    if (o.resp_cyc !== 3 || o.ready_after !== 1'b1 || o.pulse_again !== 1'b0) begin
      errors++;
      $display("FAIL min_latency: got resp@%0d ready_after=%b pulse_again=%b, want resp@3 1 0",
               o.resp_cyc, o.ready_after, o.pulse_again);
    end
    run_txn(0, 2, 32'h0000_2002, 32'h0000_BEEF, 32'h1234_5678, 0, 1, o);
    checks++;
    if ({o.be, o.wdata, o.we, o.rdata, o.err} !== {4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL sh_lanes: got be=%b wdata=%h we=%b rdata=%h err=%b, want 1100 beefbeef 1 0 0",
               o.be, o.wdata, o.we, o.rdata, o.err);
    end
    run_txn(5, 0, 32'h0000_0010, 32'h0, 32'hABCD_8001, 3, 0, o);
    checks++;
    if (o.req_cycles !== 4 || o.stable !== 1'b1 || o.addr !== 32'h10 || o.be !== 4'b0011) begin
      errors++;
      $display("FAIL lhu_stall: got req_cycles=%0d stable=%b addr=%h be=%b, want 4 1 00000010 0011",
               o.req_cycles, o.stable, o.addr, o.be);
    end
    checks++;
    if (o.rdata !== 32'h0000_8001 || o.resp_cyc !== 6) begin
      errors++;
      $display("FAIL lhu_data: got rdata=%h resp@%0d, want 00008001 resp@6", o.rdata, o.resp_cyc);
    end
    run_txn(0, 0, 32'h0000_0044, 32'hFFFF_FFFF, 32'h0, 0, 0, o);
    checks++;
    if (o.req_cycles !== 0 || o.resp_cyc !== 1 || o.rdata !== 32'h0 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL noop: got req_cycles=%0d resp@%0d rdata=%h err=%b, want 0 resp@1 0 0",
               o.req_cycles, o.resp_cyc, o.rdata, o.err);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    exp_t e;
    e = model(3, 0, 32'h0000_1001, 32'h0, 32'hCAFE_F00D, 0, 0);
    run_txn(3, 0, 32'h0000_1001, 32'h0, 32'hCAFE_F00D, 0, 0, o);
    checks++;
    if (o.req_cycles !== (e.bus ? 1 : 0) || o.err !== e.err || o.resp_cyc !== e.lat || o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL lw_misalign: got req_cycles=%0d err=%b resp@%0d rdata=%h, want %0d %b resp@%0d %h",
               o.req_cycles, o.err, o.resp_cyc, o.rdata, e.bus ? 1 : 0, e.err, e.lat, e.rdata);
    end
    if (e.bus) begin
      checks++;
      if (o.addr !== 32'h0000_1000 || o.be !== 4'b1111) begin
        errors++;
        $display("FAIL lw_truncate: got addr=%h be=%b, want 00001000 1111", o.addr, o.be);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(3, 0, 32'h0000_0200, 32'h0, 32'h0, 1, -1, o);
    checks++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.resp_cyc !== 2 + 1 + TO) begin
      errors++;
      $display("FAIL timeout: got err=%b rdata=%h resp@%0d, want 1 0 resp@%0d", o.err, o.rdata, o.resp_cyc, 3 + TO);
    end
    run_txn(3, 0, 32'h0000_0204, 32'h0, 32'h5A5A_1234, 0, TO - 1, o);
    checks++;
    if (o.err !== 1'b0 || o.rdata !== 32'h5A5A_1234) begin
      errors++;
      $display("FAIL rvalid_last_wait: got err=%b rdata=%h, want 0 5a5a1234", o.err, o.rdata);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL late_rvalid: cycle %0d got resp_valid=%b ready=%b, want 0 1", i, resp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; is_load = 3'd3; is_store = 2'd0; addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (dmem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_req: got req=%b ready=%b rv=%b, want 0 1 0", dmem_req, req_ready, resp_valid);
    end
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    dmem_gnt  = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry: got req=%b ready=%b, want 0 0", dmem_req, req_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (req_ready !== 1'b1 || dmem_req !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wait: got ready=%b req=%b rv=%b, want 1 0 0", req_ready, dmem_req, resp_valid);
    end
    dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_rvalid: cycle %0d got resp_valid=%b, want 0", i, resp_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    int ld, st, gw, rw;
    logic [31:0] a, wd, rd;
    for (int n = 0; n < 80; n++) begin
      ld = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5));
      st = int'($urandom_range(0, 3));
      a  = $urandom; wd = $urandom; rd = $urandom;
      gw = int'($urandom_range(0, 3));
      rw = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO));
      e  = model(ld, st, a, wd, rd, gw, rw);
      run_txn(ld, st, a, wd, rd, gw, rw, o);
      checks++;
      if (o.resp_cyc !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
        errors++;
        $display("FAIL rand_resp[%0d] ld=%0d st=%0d a=%h: got resp@%0d rdata=%h err=%b, want resp@%0d %h %b",
                 n, ld, st, a, o.resp_cyc, o.rdata, o.err, e.lat, e.rdata, e.err);
      end
      checks++;
      if (o.req_cycles !== (e.bus ? gw + 1 : 0) || o.stable !== 1'b1) begin
        errors++;
        $display("FAIL rand_req[%0d]: got req_cycles=%0d stable=%b, want %0d 1",
                 n, o.req_cycles, o.stable, e.bus ? gw + 1 : 0);
      end
      if (e.bus) begin
        checks++;
        if ({o.addr, o.be, o.we} !== {e.addr, e.be, e.we} || (e.we && o.wdata !== e.wdata)) begin
          errors++;
          $display("FAIL rand_bus[%0d] ld=%0d st=%0d a=%h: got addr=%h be=%b we=%b wdata=%h, want %h %b %b %h",
                   n, ld, st, a, o.addr, o.be, o.we, o.wdata, e.addr, e.be, e.we, e.wdata);
        end
      end
      checks++;
      if (o.ready_busy !== 1'b0 || o.ready_after !== 1'b1 || o.pulse_again !== 1'b0) begin
        errors++;
        $display("FAIL rand_hs[%0d]: got ready_busy=%b ready_after=%b pulse_again=%b, want 0 1 0",
                 n, o.ready_busy, o.ready_after, o.pulse_again);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] w;
    for (int n = 0; n < 4; n++) begin
      w = $urandom;
      run_txn(3, 0, 32'h0000_0300 + 32'(4 * n), 32'h0, w, 0, 0, o);
      checks++;
      if (o.resp_cyc !== 3 || o.rdata !== w || o.ready_after !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got resp@%0d rdata=%h ready_after=%b, want resp@3 %h 1",
                 n, o.resp_cyc, o.rdata, o.ready_after, w);
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_directed();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
